branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage counterpart of the tournament branch predictor.
- Holds the predictions made at fetch in an in-flight queue and retires them in order when execute resolves each branch.
- Drives the predictor's training interface (en / result / PCE).
- Raises a redirect with the correct PC and flushes wrong-path state on a mispredict.
- Keeps saturating branch and mispredict counters for performance reporting.

Parameters:
- PC_W, 18, PC width; matches predictor PCF/PCE.
- DEPTH, 4, in-flight branch queue entries; power of two, at least 2.
- PC_STEP, 4, added to the branch PC to form the fall-through redirect PC.
- FLUSH_CYCLES, 2, cycles after a redirect during which fetch_valid and ex_valid are ignored (wrong-path drain).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- fetch_valid  in  1  a branch was fetched this cycle with a prediction
- fetch_pc  in  PC_W  PC of the fetched branch
- fetch_predict  in  1  predictor output for that branch (1 = taken)
- queue_full  out  1  no free entry; fetch must stall branch issue
- ex_valid  in  1  execute resolves the oldest outstanding branch this cycle
- ex_pc  in  PC_W  PC of the resolving branch
- ex_taken  in  1  actual outcome
- ex_target  in  PC_W  actual taken target
- bp_en  out  1  predictor update strobe
- bp_result  out  1  outcome for the update
- bp_pc  out  PC_W  PC for the update (drives predictor PCE)
- redirect_valid  out  1  one-cycle pulse: refetch from redirect_pc
- redirect_pc  out  PC_W  correct next PC
- err  out  1  sticky protocol error
- branch_cnt  out  CNT_W  resolved branches, saturating
- mispredict_cnt  out  CNT_W  mispredicted branches, saturating

Behaviour:
- Reset is asynchronous. While rst is high, every output is 0 and the queue is empty (queue_full = 0). The FSM is in RUN.
- Queue:
  - FIFO of {pc, predict} entries with read and write pointers plus a count.
  - queue_full is combinational: count == DEPTH.
  - Push: fetch_valid & !queue_full & state==RUN & !mispredict_now.
  - fetch_valid while full is dropped and sets err.
  - Pop: ex_valid & state==RUN & count != 0.
  - Push and pop in the same cycle leave count unchanged; this is legal when full.
  - Pointers wrap modulo DEPTH.
- Resolution, combinational in the ex_valid cycle N:
  - mispredict_now = head.predict != ex_taken.
  - ex_pc != head.pc sets err and forces mispredict_now = 1.
  - ex_valid with an empty queue sets err and has no other effect.
- Registered outputs, valid in cycle N+1 for one cycle each:
  - bp_en = 1, bp_result = ex_taken, bp_pc = ex_pc.
  - On mispredict only: redirect_valid = 1, redirect_pc = ex_taken ? ex_target : ex_pc + PC_STEP. The sum is modulo 2^PC_W and wraps.
  - In all other cycles bp_en and redirect_valid are 0. bp_pc and redirect_pc hold their last values.
- Flush on mispredict, at edge N:
  - The queue is cleared: count = 0, pointers reset.
  - A push in the same cycle is dropped; it is wrong-path.
  - The FSM moves RUN -> DRAIN and loads a counter with FLUSH_CYCLES.
- FSM:
  - RUN: normal operation.
  - DRAIN: no push or pop, no updates. The counter decrements each cycle. At 1 the FSM returns to RUN, so the block sits in DRAIN for exactly FLUSH_CYCLES cycles.
  - ex_valid in DRAIN is ignored and is not an error.
- Counters, both saturating at 2^CNT_W-1:
  - branch_cnt increments on every valid pop.
  - mispredict_cnt increments on every mispredict.
- err is sticky until rst.

Decomposition:
- Package branch_pkg holds:
  - typedef bq_entry_t (struct {logic [PC_W-1:0] pc; logic predict;}).
  - typedef resolve_state_t (enum RUN, DRAIN).
  - Default constants PC_W and PC_STEP.
- One sub-module, branch_queue: a parameterised FIFO with push, pop, clear, head, count and full.
- The FSM, compare logic, output registers and counters stay in branch_resolve.

Test Plan:
- Correct not-taken: push pc=0x100, predict=0; next cycle ex_valid, ex_pc=0x100, ex_taken=0.
  - Expect bp_en=1, bp_result=0, bp_pc=0x100 one cycle later.
  - Expect redirect_valid=0, branch_cnt=1.
- Mispredict taken: push pc=0x200, predict=0, then pc=0x204; resolve 0x200 with taken=1, target=0x340.
  - Expect redirect_valid=1, redirect_pc=0x340, mispredict_cnt=1.
  - Expect the queue empty, and ex_valid ignored for 2 cycles.
- Mispredict not-taken with wrap: push pc=0x3FFFC, predict=1; resolve taken=0.
  - Expect redirect_pc=0x00000.
- Full queue: 4 pushes give queue_full=1.
  - A 5th fetch_valid alone sets err=1.
  - A simultaneous push+pop when full is accepted; count stays 4 and err is unchanged.
- Simultaneous fetch push and mispredict: the push is dropped; after DRAIN, ex_valid gives err=1 (empty queue).
- Reset mid-DRAIN: assert rst 1 cycle after a redirect.
  - Expect all outputs 0 immediately, state RUN, and a push accepted the first cycle after release.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and default constants for the execute-stage branch resolver.
package branch_pkg;

  localparam int PC_W    = 18;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            predict;
  } bq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } resolve_state_t;

endpackage

// File: rtl/branch_queue.sv
// In-flight branch FIFO: holds {pc, predict} per fetched branch until execute
// resolves it. Clear wins over push/pop so a flush never keeps wrong-path entries.
module branch_queue #(
  parameter int PC_W  = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [PC_W-1:0]          push_pc,
  input  logic                     push_predict,
  input  logic                     pop,
  input  logic                     clear,
  output logic [PC_W-1:0]          head_pc,
  output logic                     head_predict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  import branch_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic            pred_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head_pc      = pc_mem[rd_ptr];
  assign head_predict = pred_mem[rd_ptr];
  assign full         = (count == CW'(DEPTH));

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]   <= push_pc;
      pred_mem[wr_ptr] <= push_predict;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: retires fetch-time predictions in order,
// trains the predictor, redirects fetch on a mispredict and drains wrong-path
// traffic for FLUSH_CYCLES cycles afterwards.
//
// state | meaning
// RUN   | normal operation: pushes, pops and updates allowed
// DRAIN | wrong-path drain after a redirect: fetch/ex inputs ignored
module branch_resolve #(
  parameter int PC_W         = branch_pkg::PC_W,
  parameter int DEPTH        = 4,
  parameter int PC_STEP      = branch_pkg::PC_STEP,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              fetch_predict,
  output logic              queue_full,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_taken,
  input  logic [PC_W-1:0]   ex_target,
  output logic              bp_en,
  output logic              bp_result,
  output logic [PC_W-1:0]   bp_pc,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              err,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispredict_cnt
);
  import branch_pkg::*;

  localparam int DW = $clog2(FLUSH_CYCLES + 1);

  resolve_state_t        state, next_state;
  logic [DW-1:0]         drain_cnt, next_drain_cnt;

  logic [PC_W-1:0]       head_pc;
  logic                  head_predict;
  logic [$clog2(DEPTH):0] q_count;
  logic                  q_full;

  logic run, q_empty, pop_ok, push_ok, pc_mismatch, mispredict_now, err_set;
  logic [PC_W-1:0] fall_pc;

  assign run         = (state == RUN);
  assign q_empty     = (q_count == '0);
  assign pop_ok      = ex_valid & run & !q_empty;
  assign pc_mismatch = (ex_pc != head_pc);
  // A PC mismatch means the queue is out of step with execute; refetching is the safe recovery.
  assign mispredict_now = pop_ok & ((head_predict != ex_taken) | pc_mismatch);
  // Push into a full queue is fine when the head leaves in the same cycle.
  assign push_ok     = fetch_valid & run & (!q_full | pop_ok) & !mispredict_now;
  assign err_set     = (fetch_valid & run & q_full & !pop_ok)
                     | (pop_ok & pc_mismatch)
                     | (ex_valid & run & q_empty);
  assign fall_pc     = ex_pc + PC_W'(PC_STEP);
  assign queue_full  = q_full;

  branch_queue #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push         (push_ok),
    .push_pc      (fetch_pc),
    .push_predict (fetch_predict),
    .pop          (pop_ok),
    .clear        (mispredict_now),
    .head_pc      (head_pc),
    .head_predict (head_predict),
    .count        (q_count),
    .full         (q_full)
  );

  // FSM state and drain counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain_cnt;
    end
  end

  // Next-state: enter DRAIN on a mispredict, leave when the counter reaches 1.
  always_comb begin
    next_state     = state;
    next_drain_cnt = drain_cnt;
    case (state)
      RUN: begin
        if (mispredict_now) begin
          next_state     = DRAIN;
          next_drain_cnt = DW'(FLUSH_CYCLES);
        end
      end
      DRAIN: begin
        if (drain_cnt <= DW'(1)) begin
          next_state     = RUN;
          next_drain_cnt = '0;
        end else begin
          next_drain_cnt = drain_cnt - 1'b1;
        end
      end
      default: next_state = RUN;
    endcase
  end

  // Predictor training and redirect outputs, one cycle after resolution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_en          <= 1'b0;
      bp_result      <= 1'b0;
      bp_pc          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      bp_en          <= pop_ok;
      redirect_valid <= mispredict_now;
      if (pop_ok) begin
        bp_result <= ex_taken;
        bp_pc     <= ex_pc;
      end
      if (mispredict_now) begin
        redirect_pc <= ex_taken ? ex_target : fall_pc;
      end
    end
  end

  // Sticky error flag and saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err            <= 1'b0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (err_set) err <= 1'b1;
      if (pop_ok && (branch_cnt != '1)) branch_cnt <= branch_cnt + 1'b1;
      if (mispredict_now && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Table-driven bench for branch_resolve with a one-cycle scoreboard queue.
module tb_branch_resolve;

  localparam int PC_W  = 18;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             fetch_valid;
  logic [PC_W-1:0]  fetch_pc;
  logic             fetch_predict;
  logic             queue_full;
  logic             ex_valid;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_taken;
  logic [PC_W-1:0]  ex_target;
  logic             bp_en;
  logic             bp_result;
  logic [PC_W-1:0]  bp_pc;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  branch_resolve dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_predict  (fetch_predict),
    .queue_full     (queue_full),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .bp_en          (bp_en),
    .bp_result      (bp_result),
    .bp_pc          (bp_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .err            (err),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  typedef struct {
    logic            fv;
    logic [PC_W-1:0] fpc;
    logic            fp;
    logic            ev;
    logic [PC_W-1:0] epc;
    logic            et;
    logic [PC_W-1:0] etg;
    logic            en;
    logic            res;
    logic [PC_W-1:0] bpc;
    logic            rv;
    logic [PC_W-1:0] rpc;
    logic            full;
    logic            er;
    int              bc;
    int              mc;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  vec_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic fv, logic [PC_W-1:0] fpc, logic fp,
                              logic ev, logic [PC_W-1:0] epc, logic et, logic [PC_W-1:0] etg,
                              logic en, logic res, logic [PC_W-1:0] bpc,
                              logic rv, logic [PC_W-1:0] rpc,
                              logic full, logic er, int bc, int mc);
    vec_t v;
    v.fv = fv; v.fpc = fpc; v.fp = fp;
    v.ev = ev; v.epc = epc; v.et = et; v.etg = etg;
    v.en = en; v.res = res; v.bpc = bpc;
    v.rv = rv; v.rpc = rpc;
    v.full = full; v.er = er; v.bc = bc; v.mc = mc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_valid = 0; fetch_pc = '0; fetch_predict = 0;
    ex_valid = 0; ex_pc = '0; ex_taken = 0; ex_target = '0;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string tag, input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    fetch_valid = v.fv; fetch_pc = v.fpc; fetch_predict = v.fp;
    ex_valid = v.ev; ex_pc = v.epc; ex_taken = v.et; ex_target = v.etg;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("%s[%0d] bp_en", tag, idx), 32'(bp_en), 32'(e.en));
    chk($sformatf("%s[%0d] bp_result", tag, idx), 32'(bp_result), 32'(e.res));
    chk($sformatf("%s[%0d] bp_pc", tag, idx), 32'(bp_pc), 32'(e.bpc));
    chk($sformatf("%s[%0d] redirect_valid", tag, idx), 32'(redirect_valid), 32'(e.rv));
    chk($sformatf("%s[%0d] redirect_pc", tag, idx), 32'(redirect_pc), 32'(e.rpc));
    chk($sformatf("%s[%0d] queue_full", tag, idx), 32'(queue_full), 32'(e.full));
    chk($sformatf("%s[%0d] err", tag, idx), 32'(err), 32'(e.er));
    chk($sformatf("%s[%0d] branch_cnt", tag, idx), branch_cnt, 32'(e.bc));
    chk($sformatf("%s[%0d] mispredict_cnt", tag, idx), mispredict_cnt, 32'(e.mc));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " queue_full"}, 32'(queue_full), 32'd0);
    chk({tag, " bp_en"}, 32'(bp_en), 32'd0);
    chk({tag, " bp_result"}, 32'(bp_result), 32'd0);
    chk({tag, " bp_pc"}, 32'(bp_pc), 32'd0);
    chk({tag, " redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, " redirect_pc"}, 32'(redirect_pc), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " branch_cnt"}, branch_cnt, 32'd0);
    chk({tag, " mispredict_cnt"}, mispredict_cnt, 32'd0);
  endtask

  initial begin
    // Segment A: correct resolve, taken mispredict + drain, wrap, push dropped by flush.
    //                  fv fpc      fp  ev epc      et etg      en res bpc       rv rpc      f  er bc mc
    tbl_a.push_back(mk(1, 'h100,   0,  0, 0,       0, 0,       0, 0,  0,        0, 0,       0, 0, 0, 0));
    tbl_a.push_back(mk(0, 0,       0,  1, 'h100,   0, 0,       1, 0,  'h100,    0, 0,       0, 0, 1, 0));
    tbl_a.push_back(mk(1, 'h200,   0,  0, 0,       0, 0,       0, 0,  'h100,    0, 0,       0, 0, 1, 0));
    tbl_a.push_back(mk(1, 'h204,   0,  0, 0,       0, 0,       0, 0,  'h100,    0, 0,       0, 0, 1, 0));
    tbl_a.push_back(mk(0, 0,       0,  1, 'h200,   1, 'h340,   1, 1,  'h200,    1, 'h340,   0, 0, 2, 1));
    tbl_a.push_back(mk(0, 0,       0,  1, 'h204,   0, 0,       0, 1,  'h200,    0, 'h340,   0, 0, 2, 1));
    tbl_a.push_back(mk(0, 0,       0,  1, 'h204,   0, 0,       0, 1,  'h200,    0, 'h340,   0, 0, 2, 1));
    tbl_a.push_back(mk(1, 'h3FFFC, 1,  0, 0,       0, 0,       0, 1,  'h200,    0, 'h340,   0, 0, 2, 1));
    tbl_a.push_back(mk(0, 0,       0,  1, 'h3FFFC, 0, 'h1234,  1, 0,  'h3FFFC,  1, 'h00000, 0, 0, 3, 2));
    tbl_a.push_back(mk(0, 0,       0,  0, 0,       0, 0,       0, 0,  'h3FFFC,  0, 'h00000, 0, 0, 3, 2));
    tbl_a.push_back(mk(0, 0,       0,  0, 0,       0, 0,       0, 0,  'h3FFFC,  0, 'h00000, 0, 0, 3, 2));
    tbl_a.push_back(mk(1, 'h30,    0,  0, 0,       0, 0,       0, 0,  'h3FFFC,  0, 'h00000, 0, 0, 3, 2));
    tbl_a.push_back(mk(1, 'h34,    1,  1, 'h30,    1, 'h500,   1, 1,  'h30,     1, 'h500,   0, 0, 4, 3));
    tbl_a.push_back(mk(0, 0,       0,  0, 0,       0, 0,       0, 1,  'h30,     0, 'h500,   0, 0, 4, 3));
    tbl_a.push_back(mk(0, 0,       0,  0, 0,       0, 0,       0, 1,  'h30,     0, 'h500,   0, 0, 4, 3));
    tbl_a.push_back(mk(0, 0,       0,  1, 'h34,    1, 0,       0, 1,  'h30,     0, 'h500,   0, 1, 4, 3));
    tbl_a.push_back(mk(1, 'h40,    1,  0, 0,       0, 0,       0, 1,  'h30,     0, 'h500,   0, 1, 4, 3));
    tbl_a.push_back(mk(0, 0,       0,  1, 'h40,    0, 'h777,   1, 0,  'h40,     1, 'h44,    0, 1, 5, 4));
    tbl_a.push_back(mk(0, 0,       0,  0, 0,       0, 0,       0, 0,  'h40,     0, 'h44,    0, 1, 5, 4));

    // Segment B (after reset mid-DRAIN): first-cycle push, full queue, pc mismatch.
    tbl_b.push_back(mk(1, 'h50,    0,  0, 0,       0, 0,       0, 0,  0,        0, 0,       0, 0, 0, 0));
    tbl_b.push_back(mk(0, 0,       0,  1, 'h50,    0, 0,       1, 0,  'h50,     0, 0,       0, 0, 1, 0));
    tbl_b.push_back(mk(1, 'h10,    1,  0, 0,       0, 0,       0, 0,  'h50,     0, 0,       0, 0, 1, 0));
    tbl_b.push_back(mk(1, 'h14,    1,  0, 0,       0, 0,       0, 0,  'h50,     0, 0,       0, 0, 1, 0));
    tbl_b.push_back(mk(1, 'h18,    0,  0, 0,       0, 0,       0, 0,  'h50,     0, 0,       0, 0, 1, 0));
    tbl_b.push_back(mk(1, 'h1C,    0,  0, 0,       0, 0,       0, 0,  'h50,     0, 0,       1, 0, 1, 0));
    tbl_b.push_back(mk(1, 'h20,    1,  1, 'h10,    1, 0,       1, 1,  'h10,     0, 0,       1, 0, 2, 0));
    tbl_b.push_back(mk(1, 'h24,    0,  0, 0,       0, 0,       0, 1,  'h10,     0, 0,       1, 1, 2, 0));
    tbl_b.push_back(mk(0, 0,       0,  1, 'h14,    1, 0,       1, 1,  'h14,     0, 0,       0, 1, 3, 0));
    tbl_b.push_back(mk(0, 0,       0,  1, 'h99,    0, 0,       1, 0,  'h99,     1, 'h9D,    0, 1, 4, 1));

    // Reset state.
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl_a.size(); i++) step("A", i, tbl_a[i]);

    // Reset while still in DRAIN after the last redirect: outputs clear asynchronously.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl_b.size(); i++) step("B", i, tbl_b[i]);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
